// File: rtl/mem_sram_controller_if.sv
// rtl/mem_sram_controller_if.sv - MEM-stage request/response bus for the SRAM controller

interface mem_sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  // MEM stage side: issues the request and watches ready as its freeze
  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  // Controller side
  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/mem_sram_controller.sv
// rtl/mem_sram_controller.sv - 32-bit MEM-stage access split into two 16-bit SRAM accesses

module mem_sram_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_sram_controller_if.slave mem,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [15:0]          sram_dq_out,
  input  logic [15:0]          sram_dq_in,
  output logic                 sram_dq_oe,
  output logic                 sram_we_n
);

  localparam int          CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [31:0] BASE = 32'(ADDR_BASE);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_wr_q;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic               ready_c;
  logic               req;
  logic               last;
  logic [SRAM_AW-2:0] word_nxt;

  assign req      = mem.wr_en | mem.rd_en;
  assign last     = (cnt_q == CW'(WAIT_CYCLES - 1));
  // Offset from the SRAM window base; addresses below the base simply wrap
  assign word_nxt = (SRAM_AW-1)'((mem.address - BASE) >> 2);

  assign mem.ready     = ready_c;
  assign mem.read_data = rdata_q;
  assign sram_addr     = sram_addr_q;

  // State and phase counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, phase counting and SRAM strobes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_c     = 1'b0;
    sram_dq_out = 16'h0000;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      IDLE: begin
        ready_c = ~req;
        if (req) begin
          state_d = LO;
          cnt_d   = '0;
        end
      end
      LO: begin
        sram_dq_out = wdata_q[15:0];
        sram_dq_oe  = op_wr_q;
        // Release the strobe on the final wait cycle so address is held past we_n rising
        sram_we_n   = ~(op_wr_q && ((WAIT_CYCLES == 1) || !last));
        if (last) begin
          state_d = HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        sram_dq_out = wdata_q[31:16];
        sram_dq_oe  = op_wr_q;
        sram_we_n   = ~(op_wr_q && ((WAIT_CYCLES == 1) || !last));
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ready_c = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, SRAM address and read-data capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        op_wr_q     <= mem.wr_en;
        word_q      <= word_nxt;
        wdata_q     <= mem.write_data;
        sram_addr_q <= {word_nxt, 1'b0};
      end
      if (state_q == LO && last) begin
        sram_addr_q <= {word_q, 1'b1};
        if (!op_wr_q) rdata_q[15:0] <= sram_dq_in;
      end
      if (state_q == HI && last && !op_wr_q) begin
        rdata_q[31:16] <= sram_dq_in;
      end
    end
  end

endmodule
